// File: rtl/sipo_word_assembler_if.sv
// Handshake/bus bundle between the serial source, the word consumer and sipo_word_assembler.
// master: stimulus/consumer side; slave: the assembler itself.
interface sipo_word_assembler_if #(
    parameter int WIDTH = 16
);
    logic             sin;
    logic             sin_valid;
    logic             clr;
    logic             dout_ack;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin, sin_valid, clr, dout_ack,
        input  dout, dout_valid, busy, overrun, parity_err
    );

    modport slave (
        input  sin, sin_valid, clr, dout_ack,
        output dout, dout_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_word_assembler.sv
// Serial-in parallel-out word assembler with VALID/ACK output register and sticky overrun.
// Optional even-parity bit after each word when PARITY_CHECK_EN is defined.
module sipo_word_assembler #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sipo_word_assembler_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;
    logic             r_parity_err;

    logic             w_sample;
    logic             w_last_bit;
    logic             w_complete;
    logic             w_parity_bad;
    logic [WIDTH-1:0] w_next_shift;
    logic [WIDTH-1:0] w_word;

    assign w_sample   = bus.sin_valid && !bus.clr;
    assign w_last_bit = (r_state != ST_PARITY) && (r_count == LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_shift = r_shift;
        w_word       = r_shift;
        w_complete   = 1'b0;
        w_parity_bad = 1'b0;

        if (MSB_FIRST) w_next_shift = {r_shift[WIDTH-2:0], bus.sin};
        else           w_next_shift = {bus.sin, r_shift[WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
        // Data bits are already in r_shift; the current bit is the parity bit.
        w_word = r_shift;
        if (w_sample && r_state == ST_PARITY) begin
            if ((^r_shift) ^ bus.sin) w_parity_bad = 1'b1;
            else                      w_complete   = 1'b1;
        end
`else
        w_word     = w_next_shift;
        w_complete = w_sample && w_last_bit;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_bad;

            if (bus.clr) begin
                r_state   <= ST_IDLE;
                r_count   <= '0;
                r_overrun <= 1'b0;
            end else if (bus.sin_valid) begin
                if (r_state == ST_PARITY) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_shift <= w_next_shift;
                    if (w_last_bit) begin
                        r_count <= '0;
`ifdef PARITY_CHECK_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_count <= r_count + 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
            end

            // A completing word may replace DOUT only if the old one is gone or leaving now.
            if (w_complete) begin
                if (!r_dout_valid || bus.dout_ack) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overrun    <= 1'b1;
                end
            end else if (r_dout_valid && bus.dout_ack) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_count != '0) || (r_state == ST_PARITY);
    assign bus.overrun    = r_overrun;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
